mac_seq: RTL and testbench
==========================

Name: mac_seq

Overview:
- Sequencer for the pipelined MAC datapath (6-stage multiply + accumulate with register-file psum read/modify/write).
- On a go pulse, it first zeroes the psum region of the register file.
- It then streams every (input sample, output neuron) pair into the MAC, one per cycle, and inserts bubbles on stall.
- It drains the MAC pipeline and pulses done. It sits between the top-level control FSM and the MAC, input mux and weight memory.

Parameters:
- N_OUT, 100, psum entries / output neurons; valid MAC addresses are 0..N_OUT-1.
- N_IN, 16, input samples per data set.
- ADDR_W, 7, MAC/register-file address width.
- PIPE_LAT, 6, MAC latency from addr_in to writeback. Constraint: N_OUT > PIPE_LAT.
- IDLE_ADDR, 127, bubble address; must be >= N_OUT so the MAC suppresses writeback.
- WADDR_W, 11, weight-memory address width; must satisfy 2^WADDR_W >= N_IN*N_OUT.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high reset.
- go, in, 1, start request; sampled only in IDLE.
- stall, in, 1, pause issue (e.g. weight memory not ready); emits a bubble that cycle.
- busy, out, 1, high in CLEAR/RUN/DRAIN.
- done, out, 1, one-cycle pulse when the data set is complete.
- mac_start, out, 1, start flag to MAC; high on the first RUN issue of a data set.
- mac_addr, out, ADDR_W, addr_in to MAC; IDLE_ADDR when no valid issue.
- in_idx, out, 4, input-mux select (sample j).
- wt_addr, out, WADDR_W, weight address = j*N_OUT + k.
- clr_we, out, 1, register-file write enable used for zeroing.
- clr_addr, out, ADDR_W, zeroing address. Write data is constant 0, driven at the top level.

Behaviour:
- All outputs are registered.
- Reset values: busy 0, done 0, mac_start 0, mac_addr IDLE_ADDR, in_idx 0, wt_addr 0, clr_we 0, clr_addr 0, state IDLE, counters 0.
- Reset mid-operation aborts immediately to these values. Partial psums are left as-is.

State machine (IDLE, CLEAR, RUN, DRAIN, DONE):
- IDLE:
  - go=1 at edge t -> CLEAR; at t+1, clr_we=1, clr_addr=0.
  - go while busy is ignored; no queuing.
- CLEAR:
  - clr_addr steps 0..N_OUT-1, one per cycle; exactly N_OUT cycles with clr_we=1.
  - stall is ignored here.
  - The cycle after clr_addr=N_OUT-1: clr_we=0, state RUN.
- RUN:
  - Counters j (0..N_IN-1, outer) and k (0..N_OUT-1, inner).
  - Each non-stalled cycle issues one pair: mac_addr=k, in_idx=j, wt_addr=j*N_OUT+k.
  - Then k increments; at k=N_OUT-1, k wraps to 0 and j increments.
  - wt_addr is an incrementing counter; no multiplier.
  - mac_start=1 only on the issue with j=0, k=0. Stall on that cycle delays it and does not drop it.
  - Stall: mac_addr=IDLE_ADDR, mac_start=0, counters hold, and in_idx/wt_addr hold their last values.
  - After the issue with j=N_IN-1, k=N_OUT-1 -> DRAIN.
- DRAIN:
  - mac_addr=IDLE_ADDR for PIPE_LAT cycles, counted by a down-counter; stall is ignored.
  - Then -> DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - go asserted during DONE is ignored.

Hazard rule:
- Consecutive writes to the same psum address are N_OUT issue cycles apart, which is greater than PIPE_LAT, so there is no read-after-write hazard.
- Stalls only lengthen that spacing.

Latency:
- Unstalled, go edge to done high takes N_OUT + N_IN*N_OUT + PIPE_LAT + 1 cycles.
- Each stall cycle during RUN adds exactly one cycle.

Decomposition:
- Shared package mac_pkg holds:
  - the state encoding localparams (ST_IDLE..ST_DONE);
  - IDLE_ADDR;
  - PIPE_LAT;
  - N_OUT and N_IN defaults, shared with mac2 and the register file.
- Natural sub-module: mac_seq_cnt, a nested j/k counter with enable that exposes wrap flags and the wt_addr incrementer.

Test Plan:
- N_OUT=8, N_IN=3, PIPE_LAT=6, go pulse, no stall:
  - clr_we high 8 cycles with clr_addr 0..7;
  - 24 issues, mac_addr 0..7 repeated 3×, wt_addr 0..23;
  - mac_start exactly once with wt_addr=0;
  - done 39 cycles after the go edge.
- Same parameters, stall high for 3 cycles at issue j=1, k=4:
  - three IDLE_ADDR bubbles;
  - next issue is k=4, wt_addr=12;
  - done arrives 3 cycles later (42).
- stall high on the first RUN cycle for 2 cycles -> mac_start withheld, then asserted with mac_addr=0.
- go re-pulsed during RUN and during DONE -> ignored; exactly one done pulse; IDLE afterward.
- reset asserted mid-RUN (j=2, k=1) -> next cycle all outputs at reset values and busy=0; a new go restarts from CLEAR with clr_addr=0.
- End-to-end with the mac2 model and ramp data -> every psum[k] = Σ_j x[j]·w[j*N_OUT+k]; entries ≥ N_OUT are untouched.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: sizing defaults, bubble address and
// the sequencer state encoding.
package mac_pkg;
  localparam int N_OUT     = 100;
  localparam int N_IN      = 16;
  localparam int PIPE_LAT  = 6;
  localparam int IDLE_ADDR = 127;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } mac_state_t;
endpackage

// File: rtl/mac_seq_cnt.sv
// Nested sample/neuron counter (j outer, k inner) with a running weight
// address so the flat index j*N_OUT+k never needs a multiplier.
module mac_seq_cnt #(
  parameter int N_OUT   = 100,
  parameter int N_IN    = 16,
  parameter int ADDR_W  = 7,
  parameter int WADDR_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [3:0]         j,
  output logic [ADDR_W-1:0]  k,
  output logic [WADDR_W-1:0] w,
  output logic               k_last,
  output logic               j_last
);
  assign k_last = (k == ADDR_W'(N_OUT - 1));
  assign j_last = (j == 4'(N_IN - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      j <= '0;
      k <= '0;
      w <= '0;
    end else if (en) begin
      w <= (k_last && j_last) ? '0 : w + WADDR_W'(1);
      if (k_last) begin
        k <= '0;
        j <= j_last ? 4'd0 : j + 4'd1;
      end else begin
        k <= k + ADDR_W'(1);
      end
    end
  end
endmodule

// File: rtl/mac_seq.sv
// MAC sequencer: zero the psum region, stream every (sample, neuron) pair into
// the MAC with bubbles on stall, drain the pipeline, then pulse done.
module mac_seq #(
  parameter int N_OUT     = mac_pkg::N_OUT,
  parameter int N_IN      = mac_pkg::N_IN,
  parameter int ADDR_W    = 7,
  parameter int PIPE_LAT  = mac_pkg::PIPE_LAT,
  parameter int IDLE_ADDR = mac_pkg::IDLE_ADDR,
  parameter int WADDR_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               mac_start,
  output logic [ADDR_W-1:0]  mac_addr,
  output logic [3:0]         in_idx,
  output logic [WADDR_W-1:0] wt_addr,
  output logic               clr_we,
  output logic [ADDR_W-1:0]  clr_addr
);
  import mac_pkg::*;

  localparam int DCNT_W = $clog2(PIPE_LAT + 1);

  mac_state_t          state;
  logic [DCNT_W-1:0]   drain_cnt;
  logic [3:0]          j;
  logic [ADDR_W-1:0]   k;
  logic [WADDR_W-1:0]  w;
  logic                k_last;
  logic                j_last;
  logic                issue;

  assign issue = (state == ST_RUN) && !stall;

  mac_seq_cnt #(
    .N_OUT   (N_OUT),
    .N_IN    (N_IN),
    .ADDR_W  (ADDR_W),
    .WADDR_W (WADDR_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == ST_IDLE),
    .en     (issue),
    .j      (j),
    .k      (k),
    .w      (w),
    .k_last (k_last),
    .j_last (j_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_start <= 1'b0;
      mac_addr  <= ADDR_W'(IDLE_ADDR);
      in_idx    <= '0;
      wt_addr   <= '0;
      clr_we    <= 1'b0;
      clr_addr  <= '0;
    end else begin
      done      <= 1'b0;
      mac_start <= 1'b0;
      mac_addr  <= ADDR_W'(IDLE_ADDR);
      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            clr_we   <= 1'b1;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_addr == ADDR_W'(N_OUT - 1)) begin
            clr_we <= 1'b0;
            state  <= ST_RUN;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          // Stalled cycles fall through with the bubble defaults; select lines hold.
          if (!stall) begin
            mac_addr  <= k;
            in_idx    <= j;
            wt_addr   <= w;
            mac_start <= (j == 4'd0) && (k == '0);
            if (j_last && k_last) begin
              state     <= ST_DRAIN;
              drain_cnt <= DCNT_W'(PIPE_LAT);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DCNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: scenario table with issue/clear scoreboards and a
// behavioural MAC model, plus hand-written go-repulse and mid-run reset cases.
module tb_mac_seq;
  localparam int NO   = 8;
  localparam int NI   = 3;
  localparam int AW   = 7;
  localparam int PL   = 6;
  localparam int IDLE = 127;
  localparam int WW   = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          stall = 1'b0;
  logic          busy, done, mac_start, clr_we;
  logic [AW-1:0] mac_addr, clr_addr;
  logic [3:0]    in_idx;
  logic [WW-1:0] wt_addr;

  mac_seq #(.N_OUT(NO), .N_IN(NI), .ADDR_W(AW), .PIPE_LAT(PL), .IDLE_ADDR(IDLE), .WADDR_W(WW)) dut (
    .clk(clk), .reset(reset), .go(go), .stall(stall), .busy(busy), .done(done),
    .mac_start(mac_start), .mac_addr(mac_addr), .in_idx(in_idx), .wt_addr(wt_addr),
    .clr_we(clr_we), .clr_addr(clr_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int addr;
    int in;
    int wt;
    bit st;
  } iss_t;

  iss_t iq[$];
  int   cq[$];
  int   n_start = 0;
  int   last_wt = 0;
  int   last_in = 0;

  int x_mem [16];
  int w_mem [2048];
  int psum  [128];
  int p_addr[PL];
  int p_prod[PL];

  // Behavioural MAC plus scoreboard pop for everything the sequencer emits.
  always @(negedge clk) begin
    if (reset) begin
      last_wt = 0;
      last_in = 0;
      for (int i = 0; i < PL; i++) p_addr[i] = IDLE;
    end else begin
      if (p_addr[PL-1] < NO) psum[p_addr[PL-1]] += p_prod[PL-1];
      for (int i = PL - 1; i > 0; i--) begin
        p_addr[i] = p_addr[i-1];
        p_prod[i] = p_prod[i-1];
      end
      p_addr[0] = int'(mac_addr);
      p_prod[0] = x_mem[in_idx] * w_mem[wt_addr];
      if (clr_we) begin
        if (cq.size() == 0) chk("unexpected_clear", int'(clr_addr), -1);
        else chk("clr_addr", int'(clr_addr), cq.pop_front());
        psum[clr_addr] = 0;
      end
      if (mac_addr != AW'(IDLE)) begin
        if (iq.size() == 0) chk("unexpected_issue", int'(mac_addr), -1);
        else begin
          iss_t e;
          e = iq.pop_front();
          chk("mac_addr", int'(mac_addr), e.addr);
          chk("in_idx", int'(in_idx), e.in);
          chk("wt_addr", int'(wt_addr), e.wt);
          chk("mac_start", int'(mac_start), int'(e.st));
        end
        last_wt = int'(wt_addr);
        last_in = int'(in_idx);
        if (mac_start) n_start++;
      end else begin
        chk("start_on_bubble", int'(mac_start), 0);
        if (busy) begin
          chk("hold_wt_addr", int'(wt_addr), last_wt);
          chk("hold_in_idx", int'(in_idx), last_in);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    for (int a = 0; a < NO; a++) cq.push_back(a);
    for (int n = 0; n < NI * NO; n++) begin
      iss_t e;
      e.addr = n % NO;
      e.in   = n / NO;
      e.wt   = n;
      e.st   = (n == 0);
      iq.push_back(e);
    end
  endtask

  task automatic check_psum();
    int bad;
    for (int kk = 0; kk < NO; kk++) begin
      int s;
      s = 0;
      for (int jj = 0; jj < NI; jj++) s += x_mem[jj] * w_mem[jj * NO + kk];
      chk($sformatf("psum[%0d]", kk), psum[kk], s);
    end
    bad = 0;
    for (int i = NO; i < 128; i++) if (psum[i] != 1000 + i) bad++;
    chk("psum_above_n_out_untouched", bad, 0);
  endtask

  // One data set: stall for s_len edges starting at issue s_at; optional extra go pulses.
  task automatic run_set(input int s_at, input int s_len, input int exp_lat, input bit repulse);
    int  t;
    bit  got;
    int  lat;
    n_start = 0;
    push_expected();
    go = 1'b1;
    tick();
    t  = cyc;
    go = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int c = 0; c < 200 && !got; c++) begin
      stall = (s_len > 0) && (cyc + 1 >= t + 9 + s_at) && (cyc + 1 < t + 9 + s_at + s_len);
      go    = repulse && (cyc + 1 == t + 15);
      tick();
      if (done) begin
        got = 1'b1;
        lat = cyc - t;
      end
    end
    stall = 1'b0;
    go    = 1'b0;
    chk("done_latency", lat, exp_lat);
    chk("busy_in_done", int'(busy), 0);
    if (repulse) begin
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("done_single_pulse", int'(done), 0);
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("idle_after_go_in_done", int'({busy, clr_we, done}), 0);
      end
    end else begin
      tick();
      chk("done_single_pulse", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
    end
    chk("mac_start_count", n_start, 1);
    chk("issues_left", iq.size(), 0);
    chk("clears_left", cq.size(), 0);
    check_psum();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_mac_start"}, int'(mac_start), 0);
    chk({tag, "_mac_addr"}, int'(mac_addr), IDLE);
    chk({tag, "_in_idx"}, int'(in_idx), 0);
    chk({tag, "_wt_addr"}, int'(wt_addr), 0);
    chk({tag, "_clr_we"}, int'(clr_we), 0);
    chk({tag, "_clr_addr"}, int'(clr_addr), 0);
  endtask

  typedef struct {
    int s_at;
    int s_len;
    int exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int t;
    vecs[0] = '{0, 0, 39};
    vecs[1] = '{12, 3, 42};
    vecs[2] = '{0, 2, 41};
    vecs[3] = '{23, 1, 40};

    for (int i = 0; i < 16; i++) x_mem[i] = i + 1;
    for (int i = 0; i < 2048; i++) w_mem[i] = (i * 3) % 11 - 5;
    for (int i = 0; i < 128; i++) psum[i] = (i < NO) ? 55 : 1000 + i;
    for (int i = 0; i < PL; i++) begin
      p_addr[i] = IDLE;
      p_prod[i] = 0;
    end

    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    chk("idle_no_go_busy", int'(busy), 0);

    for (int v = 0; v < 4; v++) begin
      run_set(vecs[v].s_at, vecs[v].s_len, vecs[v].exp_lat, 1'b0);
      repeat (2) tick();
    end

    run_set(0, 0, 39, 1'b1);
    repeat (2) tick();

    // Reset lands on the edge that would issue j=2, k=1.
    push_expected();
    go = 1'b1;
    tick();
    t  = cyc;
    go = 1'b0;
    for (int c = 0; c < 100 && cyc < t + 25; c++) tick();
    chk("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    check_reset_values("midrun");
    reset = 1'b0;
    iq.delete();
    cq.delete();
    repeat (3) tick();
    chk("post_reset_idle", int'({busy, clr_we, done}), 0);
    run_set(0, 0, 39, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
